// File: rtl/rfg_axis_pkg.sv
// Shared types and constants for the rfg AXIS blocks.
//   rfg_header_t : layout of the first byte of every protocol frame
//   arb_state_e  : frame arbiter FSM states
//   Hdr*Bit      : bit positions of the header flags
package rfg_axis_pkg;

  typedef struct packed {
    logic [3:0] vchannel;
    logic       rsvd;
    logic       address_increment;
    logic       read;
    logic       write;
  } rfg_header_t;

  typedef enum logic [2:0] {
    StArb,
    StHdr,
    StAddr,
    StLenA,
    StLenB,
    StPayload
  } arb_state_e;

  localparam int unsigned HdrWriteBit   = 0;
  localparam int unsigned HdrReadBit    = 1;
  localparam int unsigned HdrAddrIncBit = 2;

endpackage

// File: rtl/rfg_axis_rr_arbiter.sv
// Combinational round-robin picker.
//   req         : per-port request vector
//   last_grant  : index of the previously served port
//   grant       : one-hot grant of the first requester after last_grant
//   grant_idx   : index of that requester
//   grant_valid : at least one request present
module rfg_axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

  int unsigned           idx;
  logic [IDX_WIDTH-1:0]  idx_sel;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_sel     = '0;
    // Scan last_grant+1 .. last_grant+NUM_PORTS, wrapping; first hit wins.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_sel = IDX_WIDTH'(idx);
      if (!grant_valid && req[idx_sel]) begin
        grant_valid      = 1'b1;
        grant[idx_sel]   = 1'b1;
        grant_idx        = idx_sel;
      end
    end
  end

endmodule

// File: rtl/rfg_axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one rfg AXIS protocol engine
// between NUM_PORTS requesters. Requests are stamped with tid = port index;
// responses are steered back by tdest.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   s_axis_*                 : per-port request streams (packed, port p at slice p)
//   m_axis_*                 : request stream to the engine, tid = granted port
//   r_s_axis_*               : response stream from the engine
//   r_m_axis_*               : response stream to ports (data/tlast broadcast)
//   frame_count              : per-port completed frame counters, present only
//                              when RFG_AXIS_ARB_STATS_EN is defined
module rfg_axis_frame_arbiter
  import rfg_axis_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [8*NUM_PORTS-1:0]          s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [USER_WIDTH*NUM_PORTS-1:0] s_axis_tuser,
  output logic [7:0]                      m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic [7:0]                      r_s_axis_tdata,
  input  logic                            r_s_axis_tvalid,
  output logic                            r_s_axis_tready,
  input  logic                            r_s_axis_tlast,
  input  logic [ID_WIDTH-1:0]             r_s_axis_tdest,
  output logic [7:0]                      r_m_axis_tdata,
  output logic [NUM_PORTS-1:0]            r_m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            r_m_axis_tready,
`ifdef RFG_AXIS_ARB_STATS_EN
  output logic [16*NUM_PORTS-1:0]         frame_count,
`endif
  output logic                            r_m_axis_tlast
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]      last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0] grant_oh_q, grant_oh_d;
  logic                 hdr_wr_q, hdr_wr_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [15:0]          remain_q, remain_d;

  logic [NUM_PORTS-1:0] arb_grant_oh;
  logic [IdxW-1:0]      arb_grant_idx;
  logic                 arb_grant_valid;
  logic                 accept;
  logic                 frame_done;

  rfg_axis_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WIDTH (IdxW)
  ) u_rr_arbiter (
    .req         (s_axis_tvalid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant_oh),
    .grant_idx   (arb_grant_idx),
    .grant_valid (arb_grant_valid)
  );

  // Request path: granted port wired straight through outside of StArb.
  assign m_axis_tdata = s_axis_tdata[grant_q*8 +: 8];
  assign m_axis_tuser = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
  assign m_axis_tid   = ID_WIDTH'(grant_q);

  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q != StArb) begin
      m_axis_tvalid = |(s_axis_tvalid & grant_oh_q);
      s_axis_tready = grant_oh_q & {NUM_PORTS{m_axis_tready}};
    end
  end

  assign accept = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    hdr_wr_d     = hdr_wr_q;
    len_lo_d     = len_lo_q;
    remain_d     = remain_q;
    frame_done   = 1'b0;

    case (state_q)
      StArb: begin
        if (arb_grant_valid) begin
          grant_d    = arb_grant_idx;
          grant_oh_d = arb_grant_oh;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (accept) begin
          hdr_wr_d = m_axis_tdata[HdrWriteBit];
          // Neither read nor write: the engine drops this byte on its own.
          if (!m_axis_tdata[HdrWriteBit] && !m_axis_tdata[HdrReadBit]) frame_done = 1'b1;
          else                                                         state_d    = StAddr;
        end
      end
      StAddr: begin
        if (accept) state_d = StLenA;
      end
      StLenA: begin
        if (accept) begin
          len_lo_d = m_axis_tdata;
          state_d  = StLenB;
        end
      end
      StLenB: begin
        if (accept) begin
          if (hdr_wr_q) begin
            remain_d = {m_axis_tdata, len_lo_q};
            state_d  = StPayload;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      StPayload: begin
        // A length of zero wraps 0 -> FFFF and ends at 1: 65536 bytes.
        if (accept) begin
          if (remain_q == 16'd1) frame_done = 1'b1;
          else                   remain_d   = remain_q - 16'd1;
        end
      end
      default: state_d = StArb;
    endcase

    if (frame_done) begin
      last_grant_d = grant_q;
      state_d      = StArb;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StArb;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IdxW'(NUM_PORTS - 1);
      hdr_wr_q     <= 1'b0;
      len_lo_q     <= '0;
      remain_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      hdr_wr_q     <= hdr_wr_d;
      len_lo_q     <= len_lo_d;
      remain_q     <= remain_d;
    end
  end

`ifdef RFG_AXIS_ARB_STATS_EN
  logic [16*NUM_PORTS-1:0] frame_count_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count_q <= '0;
    end else if (frame_done) begin
      frame_count_q[grant_q*16 +: 16] <= frame_count_q[grant_q*16 +: 16] + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  // Response path: steer by tdest; beats to nonexistent ports are sunk.
  assign r_m_axis_tdata = r_s_axis_tdata;
  assign r_m_axis_tlast = r_s_axis_tlast;

  always_comb begin
    r_m_axis_tvalid = '0;
    r_s_axis_tready = 1'b1;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (32'(r_s_axis_tdest) == p) begin
        r_m_axis_tvalid[p] = r_s_axis_tvalid;
        r_s_axis_tready    = r_m_axis_tready[p];
      end
    end
  end

endmodule

// File: tb/tb_rfg_axis_frame_arbiter.sv
module tb_rfg_axis_frame_arbiter;

  localparam int unsigned NP  = 4;
  localparam int unsigned IDW = 8;
  localparam int unsigned UW  = 1;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [8*NP-1:0]     s_axis_tdata;
  logic [NP-1:0]       s_axis_tvalid;
  logic [NP-1:0]       s_axis_tready;
  logic [UW*NP-1:0]    s_axis_tuser;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [UW-1:0]       m_axis_tuser;
  logic [IDW-1:0]      m_axis_tid;
  logic [7:0]          r_s_axis_tdata;
  logic                r_s_axis_tvalid;
  logic                r_s_axis_tready;
  logic                r_s_axis_tlast;
  logic [IDW-1:0]      r_s_axis_tdest;
  logic [7:0]          r_m_axis_tdata;
  logic [NP-1:0]       r_m_axis_tvalid;
  logic [NP-1:0]       r_m_axis_tready;
  logic                r_m_axis_tlast;
`ifdef RFG_AXIS_ARB_STATS_EN
  logic [16*NP-1:0]    frame_count;
`endif

  rfg_axis_frame_arbiter #(
    .NUM_PORTS  (NP),
    .ID_WIDTH   (IDW),
    .USER_WIDTH (UW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tuser    (s_axis_tuser),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tid      (m_axis_tid),
    .r_s_axis_tdata  (r_s_axis_tdata),
    .r_s_axis_tvalid (r_s_axis_tvalid),
    .r_s_axis_tready (r_s_axis_tready),
    .r_s_axis_tlast  (r_s_axis_tlast),
    .r_s_axis_tdest  (r_s_axis_tdest),
    .r_m_axis_tdata  (r_m_axis_tdata),
    .r_m_axis_tvalid (r_m_axis_tvalid),
    .r_m_axis_tready (r_m_axis_tready),
`ifdef RFG_AXIS_ARB_STATS_EN
    .frame_count     (frame_count),
`endif
    .r_m_axis_tlast  (r_m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        toggle_ready = 1'b0;
  logic        watch_en     = 1'b0;
  int          bad_rdy      = 0;
  int          multi_rdy    = 0;

  logic [7:0]  src_q [NP][$];
  // Monitor entry: {tuser, tid, data}
  logic [16:0] mon_q [$];

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      s_axis_tvalid[p]       = (src_q[p].size() != 0);
      s_axis_tdata[8*p +: 8] = (src_q[p].size() != 0) ? src_q[p][0] : 8'h00;
      s_axis_tuser[p]        = p[0];
    end
    m_axis_tready = toggle_ready ? cyc[0] : 1'b1;
  endtask

  // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
  task automatic cycle();
    logic [NP-1:0] acc;
    @(negedge aclk);
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) mon_q.push_back({m_axis_tuser, m_axis_tid, m_axis_tdata});
    if ($countones(s_axis_tready) > 1) multi_rdy++;
    if (watch_en && s_axis_tready[2] && src_q[0].size() != 0) bad_rdy++;
    @(posedge aclk);
    #1;
    for (int p = 0; p < NP; p++) if (acc[p]) void'(src_q[p].pop_front());
    cyc++;
    drive_inputs();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    mon_q.delete();
    toggle_ready    = 1'b0;
    watch_en        = 1'b0;
    bad_rdy         = 0;
    multi_rdy       = 0;
    r_s_axis_tdata  = 8'h00;
    r_s_axis_tvalid = 1'b0;
    r_s_axis_tlast  = 1'b0;
    r_s_axis_tdest  = '0;
    r_m_axis_tready = '0;
    drive_inputs();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    aresetn = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].push_back(8'h01);
    drive_inputs();
    @(posedge aclk);
    #1;
    n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tid !== 8'h00) begin n_fail++; $display("FAIL reset_tid: got %h want 00", m_axis_tid); end
`ifdef RFG_AXIS_ARB_STATS_EN
    n_checks++; if (frame_count !== '0) begin n_fail++; $display("FAIL reset_frame_count: got %h want 0", frame_count); end
`endif
  endtask

  task automatic test_single_write();
    logic [7:0] fr [$];
    int guard;
    do_reset();
    fr = '{8'h01, 8'h10, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    foreach (fr[i]) src_q[1].push_back(fr[i]);
    drive_inputs();
    guard = 0;
    while (mon_q.size() < 7 && guard < 40) begin cycle(); guard++; end
    n_checks++; if (mon_q.size() != 7) begin n_fail++; $display("FAIL write_count: got %0d want 7", mon_q.size()); end
    n_checks++; if (guard != 8) begin n_fail++; $display("FAIL write_cycles: got %0d want 8", guard); end
    for (int i = 0; i < 7 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== {1'b1, 8'h01, fr[i]}) begin
        n_fail++; $display("FAIL write_byte%0d: got %h want %h", i, mon_q[i], {1'b1, 8'h01, fr[i]});
      end
    end
    @(negedge aclk);
    n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL write_release: got %b want 0000", s_axis_tready); end
`ifdef RFG_AXIS_ARB_STATS_EN
    n_checks++; if (frame_count[31:16] !== 16'd1) begin n_fail++; $display("FAIL write_frame_count1: got %0d want 1", frame_count[31:16]); end
`endif
  endtask

  task automatic test_two_reads();
    logic [7:0] fr [$];
    int guard;
    do_reset();
    fr = '{8'h02, 8'h05, 8'h01, 8'h00};
    foreach (fr[i]) begin src_q[0].push_back(fr[i]); src_q[2].push_back(fr[i]); end
    toggle_ready = 1'b1;
    watch_en     = 1'b1;
    drive_inputs();
    guard = 0;
    while (mon_q.size() < 8 && guard < 60) begin cycle(); guard++; end
    n_checks++; if (mon_q.size() != 8) begin n_fail++; $display("FAIL reads_count: got %0d want 8", mon_q.size()); end
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      logic [16:0] want;
      want = (i < 4) ? {1'b0, 8'h00, fr[i]} : {1'b0, 8'h02, fr[i-4]};
      n_checks++;
      if (mon_q[i] !== want) begin n_fail++; $display("FAIL reads_byte%0d: got %h want %h", i, mon_q[i], want); end
    end
    n_checks++; if (bad_rdy != 0) begin n_fail++; $display("FAIL reads_port2_ready: got %0d cycles want 0", bad_rdy); end
    n_checks++; if (multi_rdy != 0) begin n_fail++; $display("FAIL reads_onehot_ready: got %0d cycles want 0", multi_rdy); end
  endtask

  task automatic test_discard_header();
    logic [7:0] fr [$];
    int guard;
    do_reset();
    fr = '{8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h11, 8'h22};
    foreach (fr[i]) src_q[0].push_back(fr[i]);
    drive_inputs();
    guard = 0;
    while (mon_q.size() < 7 && guard < 40) begin cycle(); guard++; end
    n_checks++; if (mon_q.size() != 7) begin n_fail++; $display("FAIL discard_count: got %0d want 7", mon_q.size()); end
    // One extra arbitration cycle after the discarded header.
    n_checks++; if (guard != 9) begin n_fail++; $display("FAIL discard_cycles: got %0d want 9", guard); end
    for (int i = 0; i < 7 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i][15:0] !== {8'h00, fr[i]}) begin
        n_fail++; $display("FAIL discard_byte%0d: got %h want %h", i, mon_q[i][15:0], {8'h00, fr[i]});
      end
    end
    @(negedge aclk);
    n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL discard_release: got %b want 0000", s_axis_tready); end
`ifdef RFG_AXIS_ARB_STATS_EN
    n_checks++; if (frame_count[15:0] !== 16'd2) begin n_fail++; $display("FAIL discard_frame_count0: got %0d want 2", frame_count[15:0]); end
`endif
  endtask

  task automatic test_response();
    do_reset();
    r_s_axis_tdest  = 8'd3;
    r_s_axis_tdata  = 8'h5A;
    r_s_axis_tvalid = 1'b1;
    r_s_axis_tlast  = 1'b0;
    r_m_axis_tready = 4'b0000;
    #1;
    n_checks++; if (r_m_axis_tvalid !== 4'b1000) begin n_fail++; $display("FAIL resp_valid3: got %b want 1000", r_m_axis_tvalid); end
    n_checks++; if (r_s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL resp_stall: got %b want 0", r_s_axis_tready); end
    n_checks++; if (r_m_axis_tdata !== 8'h5A) begin n_fail++; $display("FAIL resp_data0: got %h want 5a", r_m_axis_tdata); end
    r_m_axis_tready = 4'b1000;
    #1;
    n_checks++; if (r_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL resp_ready3: got %b want 1", r_s_axis_tready); end
    r_s_axis_tdata  = 8'hA5;
    r_s_axis_tlast  = 1'b1;
    r_m_axis_tready = 4'b0111;
    #1;
    n_checks++; if (r_s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL resp_others_ready: got %b want 0", r_s_axis_tready); end
    n_checks++; if (r_m_axis_tlast !== 1'b1) begin n_fail++; $display("FAIL resp_tlast: got %b want 1", r_m_axis_tlast); end
    n_checks++; if (r_m_axis_tdata !== 8'hA5) begin n_fail++; $display("FAIL resp_data1: got %h want a5", r_m_axis_tdata); end
    r_s_axis_tdest  = 8'd9;
    r_m_axis_tready = 4'b0000;
    #1;
    n_checks++; if (r_m_axis_tvalid !== 4'b0000) begin n_fail++; $display("FAIL resp_drop_valid: got %b want 0000", r_m_axis_tvalid); end
    n_checks++; if (r_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL resp_drop_ready: got %b want 1", r_s_axis_tready); end
    r_s_axis_tdest  = 8'd0;
    r_m_axis_tready = 4'b0001;
    #1;
    n_checks++; if (r_m_axis_tvalid !== 4'b0001) begin n_fail++; $display("FAIL resp_valid0: got %b want 0001", r_m_axis_tvalid); end
    n_checks++; if (r_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL resp_ready0: got %b want 1", r_s_axis_tready); end
    r_s_axis_tvalid = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [7:0] rd [$];
    int guard;
    int n0;
    int bad;
    do_reset();
    src_q[0].push_back(8'h01); src_q[0].push_back(8'h00);
    src_q[0].push_back(8'h00); src_q[0].push_back(8'h00);
    for (int i = 0; i < 65536; i++) src_q[0].push_back(i[7:0]);
    rd = '{8'h02, 8'h07, 8'h01, 8'h00};
    foreach (rd[i]) src_q[1].push_back(rd[i]);
    drive_inputs();
    guard = 0;
    while (mon_q.size() < 65544 && guard < 65600) begin cycle(); guard++; end
    n_checks++; if (mon_q.size() != 65544) begin n_fail++; $display("FAIL zlen_count: got %0d want 65544", mon_q.size()); end
    n0 = 0;
    while (n0 < mon_q.size() && mon_q[n0][15:8] == 8'h00) n0++;
    n_checks++; if (n0 != 65540) begin n_fail++; $display("FAIL zlen_port0_bytes: got %0d want 65540", n0); end
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] want;
      want = i[7:0];
      if (4 + i >= mon_q.size() || mon_q[4+i][7:0] !== want) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zlen_payload: got %0d bad bytes want 0", bad); end
    for (int k = 0; k < 4 && 65540 + k < mon_q.size(); k++) begin
      n_checks++;
      if (mon_q[65540+k][15:0] !== {8'h01, rd[k]}) begin
        n_fail++; $display("FAIL zlen_next%0d: got %h want %h", k, mon_q[65540+k][15:0], {8'h01, rd[k]});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    do_reset();
    src_q[2].push_back(8'h01); src_q[2].push_back(8'h00);
    src_q[2].push_back(8'h10); src_q[2].push_back(8'h00);
    for (int i = 0; i < 16; i++) src_q[2].push_back(8'h30 + 8'(i));
    drive_inputs();
    guard = 0;
    while (mon_q.size() < 6 && guard < 40) begin cycle(); guard++; end
    src_q[0].push_back(8'h02); src_q[0].push_back(8'h01);
    src_q[0].push_back(8'h01); src_q[0].push_back(8'h00);
    drive_inputs();
    cycle();
    cycle();
    n_checks++; if (s_axis_tready !== 4'b0100) begin n_fail++; $display("FAIL midrst_owner: got %b want 0100", s_axis_tready); end
    #2 aresetn = 1'b0;
    #1;
    n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL midrst_tready: got %b want 0000", s_axis_tready); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_tvalid: got %b want 0", m_axis_tvalid); end
    aresetn = 1'b1;
    mon_q.delete();
    guard = 0;
    while (mon_q.size() < 1 && guard < 10) begin cycle(); guard++; end
    n_checks++; if (mon_q.size() < 1) begin n_fail++; $display("FAIL midrst_regrant_timeout: got 0 bytes want 1"); end
    else begin
      n_checks++;
      if (mon_q[0][15:0] !== 16'h0002) begin n_fail++; $display("FAIL midrst_first: got %h want 0002", mon_q[0][15:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_reads();
    test_discard_header();
    test_response();
    test_zero_len();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rfg_axis_frame_arbiter.md
# rfg_axis_frame_arbiter

Shares one rfg AXIS protocol engine between up to NUM_PORTS I/O interfaces (UART, SPI, FTDI bridges, …). Round-robin arbitration happens at frame granularity: a granted port owns the engine's slave input until its complete protocol frame (header, address, two length bytes, write payload) has been forwarded. The engine echoes `tid` into its response `tdest`; the block stamps `tid` with the port index and demultiplexes responses back to the originating port by `tdest`.

## Interface
- NUM_PORTS, 4, number of requester ports, 2..16
- ID_WIDTH, 8, width of `tid`/`tdest` on all ports
- USER_WIDTH, 1, `tuser` width, passed through unchanged
- aclk  in  1  single clock for the whole block
- aresetn  in  1  reset; asynchronous, active-low
- s_axis_tdata  in  8*NUM_PORTS  request bytes, port p at [8p+7:8p]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tuser  in  USER_WIDTH*NUM_PORTS  per-port user
- m_axis_tdata / tvalid / tready(in) / tuser  out  8/1/1/USER_WIDTH  request stream to the engine slave
- m_axis_tid  out  ID_WIDTH  index of the granted port, zero-extended
- r_s_axis_tdata / tvalid / tready(out) / tlast / tdest(in)  in  8/1/1/1/ID_WIDTH  response stream from the engine master
- r_m_axis_tdata  out  8  response bytes, broadcast to all ports
- r_m_axis_tvalid  out  NUM_PORTS  one-hot response valid
- r_m_axis_tready  in  NUM_PORTS  per-port response ready
- r_m_axis_tlast  out  1  broadcast tlast
- frame_count  out  16*NUM_PORTS  completed frames per port (RFG_AXIS_ARB_STATS_EN only)

## Operation
- FSM states: ARB, HDR, ADDR, LENA, LENB, PAYLOAD. Only ARB runs arbitration.
- ARB: if any `s_axis_tvalid` is set, grant the first requesting port at or after `last_grant+1` (modulo NUM_PORTS), register the grant, and go to HDR. No bytes are forwarded in ARB.
- In all other states, the granted port is connected combinationally: `m_axis_tvalid = s_axis_tvalid[g]`, `s_axis_tready[g] = m_axis_tready`. All other `s_axis_tready` are 0. A byte is consumed on `tvalid && tready`.
- HDR: latch header bits [1:0] of the consumed byte.
  - If both bits are 0, the engine discards the byte. Release the grant and return to ARB.
  - Otherwise go to ADDR.
- ADDR → LENA → LENB: one accepted byte each. LENA and LENB latch `len[7:0]` and `len[15:8]`.
- On LENB accept:
  - If write bit is set (write takes precedence over read), load `remain = {byte, len[7:0]}` and go to PAYLOAD.
  - Otherwise (read-only) release and return to ARB.
- PAYLOAD: decrement `remain` on each accepted byte. The frame ends on the byte accepted while `remain == 1`. `len = 0` is treated as 65536 bytes: the 16-bit down-counter wraps from 0 to FFFF and the frame still ends at 1, matching the engine.
- Release: `last_grant <= g`, then ARB.
- Response path is combinational:
  - `r_m_axis_tvalid[p] = r_s_axis_tvalid && tdest == p`
  - `r_s_axis_tready = r_m_axis_tready[tdest]`
  - If `tdest >= NUM_PORTS`, force `r_s_axis_tready = 1` and drop the beat.

## Timing
- Reset values:
  - state ARB, `last_grant = NUM_PORTS-1` (port 0 has first priority)
  - all `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tid = 0`, `frame_count = 0`
- Data latency: zero cycles through the granted path. Overhead is exactly one ARB cycle per frame.
- A port that stalls mid-frame holds the grant indefinitely. No timeout exists; other ports wait.
- New requests arriving during a frame are ignored until ARB.
- Reset asserted mid-frame aborts the frame immediately. The engine is reset by the same `aresetn`.

## Configuration
- Macro: RFG_AXIS_ARB_STATS_EN.
- Defined: per-port 16-bit `frame_count`, incremented on release of a frame from that port, including discarded headers. Wraps from FFFF to 0.
- Undefined: no counters are built and the `frame_count` port is absent.

## Structure
- Shared package `rfg_axis_pkg`:
  - `rfg_header_t` (vchannel[7:4], rsvd, address_increment, read, write)
  - the arbiter FSM state enum
  - the header bit index constants
- Sub-module `rfg_axis_rr_arbiter`: takes the NUM_PORTS request vector and `last_grant`, returns the one-hot grant and its index. Purely combinational.

## Test plan
- Port 1 only, write frame 01 10 03 00 AA BB CC → engine sees 7 bytes with `tid = 1`. Grant returns to ARB after CC. `frame_count[1] = 1`.
- Ports 0 and 2 both request 4-byte read frames (02 05 01 00) → order is port 0 then port 2. Port 2's tready stays 0 throughout port 0's frame.
- Port 0 sends header 00 then a write frame → header released after 1 byte, then the write frame is re-arbitrated.
- Engine response with `tdest = 3`, 2 bytes plus tlast, and `r_m_axis_tready[3]` toggled → bytes appear only on port 3, stalling correctly. `tdest = 9` with NUM_PORTS = 4 → beat dropped, `tready = 1`.
- Write with len 00 00 → arbiter holds the grant for 65536 payload bytes, then releases.
- Assert `aresetn` during PAYLOAD → all readies 0 asynchronously. After release, port 0 is granted first.
